// File: rtl/cordic_hyp_iter_sched.sv
// Iteration scheduler for the expanded-range hyperbolic CORDIC exponential datapath.
// Optional WAIT watchdog with ERR_TIMEOUT: define SCHED_TIMEOUT_EN (adds the TIMEOUT parameter).
module cordic_hyp_iter_sched #(
  parameter int M_NEG  = 2,
  parameter int N_ITER = 16,
  parameter int CW     = 6
`ifdef SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sign_z,
  input  logic          ack_sumx,
  input  logic          ack_sumy,
  input  logic          ack_sumz,
  output logic          busy,
  output logic          begin_sumx,
  output logic          begin_sumy,
  output logic          begin_sumz,
  output logic          add_subt,
  output logic          sel_init,
  output logic          en_reg1xyz,
  output logic          neg_phase,
  output logic [CW-1:0] iter_idx,
  output logic [CW-1:0] lut_addr,
  output logic          done,
  output logic          err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_LATCH, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [2:0]    flags, flags_n, acks;
  logic          rep, rep_n;
  logic          all_acked, is_rep_idx, last_op;
  logic [CW-1:0] idx_n, lut_n;
  logic          add_subt_n, busy_n, begin_n, sel_init_n, en_reg_n, neg_n, done_n;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             err_n;
`else
  assign err_timeout = 1'b0;
`endif

  // Next state plus next values of every registered output
  always_comb begin
    state_n    = state;
    flags_n    = flags;
    rep_n      = rep;
    idx_n      = iter_idx;
    add_subt_n = add_subt;
`ifdef SCHED_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
    err_n      = err_timeout;
`endif
    acks       = {ack_sumz, ack_sumy, ack_sumx};
    all_acked  = &(flags | acks);
    is_rep_idx = (iter_idx == CW'(4)) || (iter_idx == CW'(13));
    last_op    = (iter_idx == CW'(N_ITER)) && !(is_rep_idx && !rep);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_INIT;
          idx_n      = CW'(-M_NEG);
          rep_n      = 1'b0;
          flags_n    = '0;
          add_subt_n = 1'b0;
`ifdef SCHED_TIMEOUT_EN
          err_n      = 1'b0;
`endif
        end
      end
      S_INIT: state_n = S_ISSUE;
      S_ISSUE: begin
        state_n    = S_WAIT;
        flags_n    = flags | acks;
        add_subt_n = sign_z;
`ifdef SCHED_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      S_WAIT: begin
        flags_n = flags | acks;
        if (all_acked) begin
          state_n = S_LATCH;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
`endif
      end
      S_LATCH: begin
        flags_n = '0;
        // Indices 4 and 13 run twice to keep hyperbolic CORDIC convergent
        if (last_op) begin
          state_n = S_DONE;
        end else begin
          state_n = S_ISSUE;
          if (is_rep_idx && !rep) begin
            rep_n = 1'b1;
          end else begin
            rep_n = 1'b0;
            idx_n = iter_idx + CW'(1);
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n     = (state_n != S_IDLE);
    begin_n    = (state_n == S_ISSUE);
    sel_init_n = (state_n == S_INIT);
    en_reg_n   = (state_n == S_INIT) || (state_n == S_LATCH);
    done_n     = (state_n == S_DONE);
    lut_n      = idx_n + CW'(M_NEG);
    neg_n      = (state_n inside {S_INIT, S_ISSUE, S_WAIT, S_LATCH}) &&
                 (idx_n[CW-1] || (idx_n == '0));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      flags      <= '0;
      rep        <= 1'b0;
      busy       <= 1'b0;
      begin_sumx <= 1'b0;
      begin_sumy <= 1'b0;
      begin_sumz <= 1'b0;
      add_subt   <= 1'b0;
      sel_init   <= 1'b0;
      en_reg1xyz <= 1'b0;
      neg_phase  <= 1'b0;
      iter_idx   <= '0;
      lut_addr   <= '0;
      done       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      flags      <= flags_n;
      rep        <= rep_n;
      busy       <= busy_n;
      begin_sumx <= begin_n;
      begin_sumy <= begin_n;
      begin_sumz <= begin_n;
      add_subt   <= add_subt_n;
      sel_init   <= sel_init_n;
      en_reg1xyz <= en_reg_n;
      neg_phase  <= neg_n;
      iter_idx   <= idx_n;
      lut_addr   <= lut_n;
      done       <= done_n;
`ifdef SCHED_TIMEOUT_EN
      wait_cnt    <= wait_cnt_n;
      err_timeout <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_cordic_hyp_iter_sched.sv
// Directed bench for cordic_hyp_iter_sched: sequence, ack ordering, direction, start/ack
// filtering, mid-run reset, and (with SCHED_TIMEOUT_EN) the WAIT timeout.
`timescale 1ns/1ps
module tb_cordic_hyp_iter_sched;
  localparam int CW = 6;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign_z = 1'b0;
  logic ack_sumx, ack_sumy, ack_sumz;
  logic busy, begin_sumx, begin_sumy, begin_sumz, add_subt, sel_init, en_reg1xyz;
  logic neg_phase, done, err_timeout;
  logic [CW-1:0] iter_idx, lut_addr;

  logic auto_ack = 1'b1, auto_a = 1'b0, hold_z = 1'b0;
  logic man_x = 1'b0, man_y = 1'b0, man_z = 1'b0;
  int   ack_dly = 1, ack_cnt = 0;
  int   total = 0, bad = 0;

  int seen_idx [32];
  int seen_lut [32];
  int seen_cyc [32];
  bit seen_neg [32];
  bit seen_bsame [32];
  int exp_idx [21] = '{-2, -1, 0, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};

  cordic_hyp_iter_sched #(
    .M_NEG(2), .N_ITER(16), .CW(CW)
`ifdef SCHED_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign_z(sign_z),
    .ack_sumx(ack_sumx), .ack_sumy(ack_sumy), .ack_sumz(ack_sumz),
    .busy(busy), .begin_sumx(begin_sumx), .begin_sumy(begin_sumy), .begin_sumz(begin_sumz),
    .add_subt(add_subt), .sel_init(sel_init), .en_reg1xyz(en_reg1xyz), .neg_phase(neg_phase),
    .iter_idx(iter_idx), .lut_addr(lut_addr), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Adder model: ack ack_dly cycles after the BEGIN cycle
  always @(posedge clk) begin
    #1;
    if (ack_cnt != 0) begin
      ack_cnt = ack_cnt - 1;
      auto_a  = (ack_cnt == 0);
    end else begin
      auto_a = 1'b0;
    end
    if (begin_sumx) ack_cnt = ack_dly;
  end

  assign ack_sumx = auto_ack ? auto_a : man_x;
  assign ack_sumy = auto_ack ? auto_a : man_y;
  assign ack_sumz = auto_ack ? (auto_a & ~hold_z) : man_z;

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Runs until DONE (bounded); records per-op observations, no checking here
  task automatic run_to_done(input bit do_start, input int spam_op, input int hold_op,
                             output int ops, output int latches, output int done_cyc,
                             output bit err_seen);
    ops = 0; latches = 0; done_cyc = -1; err_seen = 1'b0;
    if (do_start) start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (begin_sumx) begin
        if (ops < 32) begin
          seen_idx[ops]   = int'($signed(iter_idx));
          seen_lut[ops]   = int'(lut_addr);
          seen_neg[ops]   = neg_phase;
          seen_bsame[ops] = begin_sumy && begin_sumz;
          seen_cyc[ops]   = c;
        end
        ops++;
        if (hold_op >= 0 && ops == hold_op + 1) hold_z = 1'b1;
      end
      if (en_reg1xyz && !sel_init) latches++;
      if (done) begin
        done_cyc = c;
        err_seen = err_timeout;
        break;
      end
      if (spam_op >= 0 && ops == spam_op + 1) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    total++;
    if ({busy, begin_sumx, begin_sumy, begin_sumz, add_subt, sel_init, en_reg1xyz,
         neg_phase, done, err_timeout} !== 10'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {busy, begin_sumx, sel_init, en_reg1xyz, done});
    end
    total++;
    if (iter_idx !== '0 || lut_addr !== '0) begin
      bad++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", iter_idx, lut_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_nominal();
    int ops, latches, dc; bit e;
    ack_dly = 1;
    run_to_done(1'b1, -1, -1, ops, latches, dc, e);
    total++;
    if (ops !== 21) begin bad++; $display("FAIL nom_ops got=%0d exp=21", ops); end
    total++;
    if (latches !== 21) begin bad++; $display("FAIL nom_latches got=%0d exp=21", latches); end
    total++;
    if (dc !== 65) begin bad++; $display("FAIL nom_done_cycle got=%0d exp=65", dc); end
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL nom_err got=%b exp=0", e); end
    for (int i = 0; i < 21 && i < ops; i++) begin
      total++;
      if (seen_idx[i] !== exp_idx[i]) begin
        bad++; $display("FAIL nom_idx op%0d got=%0d exp=%0d", i, seen_idx[i], exp_idx[i]);
      end
      total++;
      if (seen_lut[i] !== exp_idx[i] + 2) begin
        bad++; $display("FAIL nom_lut op%0d got=%0d exp=%0d", i, seen_lut[i], exp_idx[i] + 2);
      end
      total++;
      if (seen_neg[i] !== (i < 3)) begin
        bad++; $display("FAIL nom_neg op%0d got=%b exp=%b", i, seen_neg[i], (i < 3));
      end
      total++;
      if (seen_bsame[i] !== 1'b1) begin
        bad++; $display("FAIL nom_begin_yz op%0d got=%b exp=1", i, seen_bsame[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL nom_after_done got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_ack_order();
    int n_en, k_en, ops, latches, dc; bit e, got;
    idle_cycles(1);
    auto_ack = 1'b0; got = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 6 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (begin_sumx) got = 1'b1;
    end
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL ack_first_begin got=%b exp=1", got); end
    n_en = 0; k_en = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (en_reg1xyz) begin n_en++; k_en = k; end
      man_x = (k == 1) || (k == 6);
      man_z = (k == 3) || (k == 6);
      man_y = (k == 5) || (k == 6);
    end
    total++;
    if (n_en !== 1) begin bad++; $display("FAIL ack_en_count got=%0d exp=1", n_en); end
    total++;
    if (k_en !== 6) begin bad++; $display("FAIL ack_en_cycle got=%0d exp=6", k_en); end
    run_to_done(1'b0, -1, -1, ops, latches, dc, e);
    total++;
    if (ops !== 20 || latches !== 20) begin
      bad++; $display("FAIL ack_rest got=%0d/%0d exp=20/20", ops, latches);
    end
    man_x = 1'b0; man_y = 1'b0; man_z = 1'b0; auto_ack = 1'b1;
  endtask

  task automatic test_direction();
    int ops, latches, dc; bit e, got;
    idle_cycles(1);
    auto_ack = 1'b0; got = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 6 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (begin_sumx) got = 1'b1;
    end
    sign_z = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total++;
      if (add_subt !== (k <= 5)) begin
        bad++; $display("FAIL dir_add_subt k%0d got=%b exp=%b", k, add_subt, (k <= 5));
      end
      if (k == 4 || k == 8) begin
        total++;
        if (en_reg1xyz !== 1'b1) begin bad++; $display("FAIL dir_latch k%0d got=%b exp=1", k, en_reg1xyz); end
      end
      sign_z = (k == 2) || (k == 4) || (k == 6) || (k == 8);
      man_x = (k == 3) || (k == 7) || (k == 8);
      man_y = man_x; man_z = man_x;
    end
    run_to_done(1'b0, -1, -1, ops, latches, dc, e);
    total++;
    if (dc < 0) begin bad++; $display("FAIL dir_finish got=%0d exp=done", dc); end
    man_x = 1'b0; man_y = 1'b0; man_z = 1'b0; auto_ack = 1'b1; sign_z = 1'b0;
  endtask

  task automatic test_start_ack_filter();
    int ops, latches, dc; bit e, stray;
    idle_cycles(1);
    run_to_done(1'b1, 5, -1, ops, latches, dc, e);
    total++;
    if (ops !== 21 || latches !== 21) begin
      bad++; $display("FAIL filt_ops got=%0d/%0d exp=21/21", ops, latches);
    end
    total++;
    if (dc !== 65) begin bad++; $display("FAIL filt_done_cycle got=%0d exp=65", dc); end
    start = 1'b1;  // during the DONE cycle
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL filt_start_in_done got=%b exp=0", busy); end
    auto_ack = 1'b0; stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      man_x = k[0]; man_y = 1'b1; man_z = ~k[0];
      @(posedge clk); #1;
      if (en_reg1xyz || begin_sumx || busy) stray = 1'b1;
    end
    man_x = 1'b0; man_y = 1'b0; man_z = 1'b0; auto_ack = 1'b1;
    idle_cycles(1);
    total++;
    if (stray !== 1'b0) begin bad++; $display("FAIL filt_idle_acks got=%b exp=0", stray); end
  endtask

  task automatic test_reset_mid_run();
    int ops, latches, dc; bit e, dseen;
    ack_dly = 3; ops = 0;
    start = 1'b1;
    for (int c = 0; c < 200 && ops < 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (begin_sumx) ops++;
    end
    @(posedge clk); #1;  // first WAIT cycle of op 7
    total++;
    if (busy !== 1'b1 || $signed(iter_idx) !== 6'sd4) begin
      bad++; $display("FAIL rst_pre busy=%b idx=%0d exp=1/4", busy, $signed(iter_idx));
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, begin_sumx, add_subt, sel_init, en_reg1xyz, neg_phase, done, err_timeout} !== 8'b0 ||
        iter_idx !== '0 || lut_addr !== '0) begin
      bad++; $display("FAIL rst_async got=%b idx=%0d exp=0", {busy, en_reg1xyz, done}, iter_idx);
    end
    dseen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) dseen = 1'b1;
    end
    total++;
    if (dseen !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b exp=0", dseen); end
    ack_dly = 1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_to_done(1'b1, -1, -1, ops, latches, dc, e);
    total++;
    if (ops !== 21 || dc !== 65) begin
      bad++; $display("FAIL rst_rerun got=%0d ops done@%0d exp=21 done@65", ops, dc);
    end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int ops, latches, dc; bit e;
    idle_cycles(1);
    run_to_done(1'b1, -1, 2, ops, latches, dc, e);
    hold_z = 1'b0;
    total++;
    if (ops !== 3 || latches !== 2) begin
      bad++; $display("FAIL to_ops got=%0d/%0d exp=3/2", ops, latches);
    end
    total++;
    if (dc - seen_cyc[2] !== 21) begin
      bad++; $display("FAIL to_done_delay got=%0d exp=21", dc - seen_cyc[2]);
    end
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", e); end
    idle_cycles(1);
    run_to_done(1'b1, -1, -1, ops, latches, dc, e);
    total++;
    if (e !== 1'b0 || ops !== 21) begin
      bad++; $display("FAIL to_err_clear got=%b/%0d exp=0/21", e, ops);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_ack_order();
    test_direction();
    test_start_ack_filter();
    test_reset_mid_run();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
